// File: rtl/gray_updown_counter_if.sv
// Control and status bundle for gray_updown_counter.
// The master drives the step/load controls; the slave (the counter) returns the registered code and index.
interface gray_updown_counter_if #(
  parameter int WIDTH = 3,
  parameter int IDXW  = 3
);
  logic             en;
  logic             dir;
  logic             load;
  logic [IDXW-1:0]  load_idx;
  logic [WIDTH-1:0] state;
  logic [IDXW-1:0]  index;
  logic             wrap;
  logic             err;

  modport master (
    output en, dir, load, load_idx,
    input  state, index, wrap, err
  );

  modport slave (
    input  en, dir, load, load_idx,
    output state, index, wrap, err
  );
endinterface

// File: rtl/gray_updown_counter.sv
// Up/down sequence counter whose code changes one bit per step.
// The code is either Johnson (2*WIDTH states) or reflected Gray (2^WIDTH states).
module gray_updown_counter #(
  parameter int WIDTH     = 3,
  parameter int MODE      = 0,
  parameter int RESET_IDX = 0
) (
  input logic                    clk,
  input logic                    rst,
  gray_updown_counter_if.slave   bus
);
  localparam int MOD  = (MODE == 1) ? (1 << WIDTH) : (2 * WIDTH);
  localparam int IDXW = (MOD <= 2) ? 1 : $clog2(MOD);

  function automatic logic [WIDTH-1:0] encode(input logic [IDXW-1:0] k);
    logic [WIDTH-1:0] code;
    int               ki;
    code = '0;
    ki   = int'(k);
    if (MODE == 1) begin
      code = WIDTH'(k ^ (k >> 1));
    end else begin
      // Johnson: ones fill from the bottom, then zeros fill from the bottom.
      for (int i = 0; i < WIDTH; i++) begin
        code[i] = (ki <= WIDTH) ? (i < ki) : (i >= ki - WIDTH);
      end
    end
    return code;
  endfunction

  localparam logic [IDXW-1:0]  RESET_INDEX = IDXW'(RESET_IDX);
  localparam logic [IDXW-1:0]  LAST_INDEX  = IDXW'(MOD - 1);

  logic [IDXW-1:0]  index_reg, index_next;
  logic [WIDTH-1:0] state_reg, state_next;
  logic             wrap_reg, wrap_next;
  logic             err_reg, err_next;

  always_comb begin
    index_next = index_reg;
    wrap_next  = 1'b0;
    err_next   = err_reg;
    if (bus.load) begin
      if (int'(bus.load_idx) < MOD) begin
        index_next = bus.load_idx;
      end else begin
        index_next = '0;
        err_next   = 1'b1;
      end
    end else if (int'(index_reg) >= MOD) begin
      // Corrupted index recovers to the start without flagging an error.
      index_next = '0;
    end else if (bus.en) begin
      if (!bus.dir) begin
        if (index_reg == LAST_INDEX) begin
          index_next = '0;
          wrap_next  = 1'b1;
        end else begin
          index_next = index_reg + IDXW'(1);
        end
      end else begin
        if (index_reg == '0) begin
          index_next = LAST_INDEX;
          wrap_next  = 1'b1;
        end else begin
          index_next = index_reg - IDXW'(1);
        end
      end
    end
    state_next = encode(index_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index_reg <= RESET_INDEX;
      state_reg <= encode(RESET_INDEX);
      wrap_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      index_reg <= index_next;
      state_reg <= state_next;
      wrap_reg  <= wrap_next;
      err_reg   <= err_next;
    end
  end

  assign bus.state = state_reg;
  assign bus.index = index_reg;
  assign bus.wrap  = wrap_reg;
  assign bus.err   = err_reg;
endmodule

// File: tb/tb_gray_updown_counter.sv
// Self-checking bench: a Johnson (WIDTH=3) and a Gray (WIDTH=4) instance checked against an index-level model.
module tb_gray_updown_counter;
  localparam int J_W = 3, J_MOD = 6,  J_IDXW = 3;
  localparam int G_W = 4, G_MOD = 16, G_IDXW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gray_updown_counter_if #(.WIDTH(J_W), .IDXW(J_IDXW)) jb ();
  gray_updown_counter_if #(.WIDTH(G_W), .IDXW(G_IDXW)) gb ();

  gray_updown_counter #(.WIDTH(J_W), .MODE(0), .RESET_IDX(0)) dut_j (.clk(clk), .rst(rst), .bus(jb));
  gray_updown_counter #(.WIDTH(G_W), .MODE(1), .RESET_IDX(0)) dut_g (.clk(clk), .rst(rst), .bus(gb));

  int errors = 0;
  int checks = 0;

  // Code tables built constructively: Johnson by twisted-ring shifting, Gray by reflection.
  logic [J_W-1:0] jtab [J_MOD];
  logic [G_W-1:0] gtab [G_MOD];

  int mj_idx, mg_idx;
  bit mj_wrap, mj_err, mg_wrap, mg_err;

  task automatic build_tables();
    jtab[0] = '0;
    for (int k = 1; k < J_MOD; k++) jtab[k] = {jtab[k-1][J_W-2:0], ~jtab[k-1][J_W-1]};
    gtab[0] = '0;
    for (int b = 0; b < G_W; b++)
      for (int i = 0; i < (1 << b); i++)
        gtab[(1 << b) + i] = gtab[(1 << b) - 1 - i] | G_W'(1 << b);
  endtask

  task automatic model_reset();
    mj_idx = 0; mj_wrap = 0; mj_err = 0;
    mg_idx = 0; mg_wrap = 0; mg_err = 0;
  endtask

  task automatic model_step(inout int idx, inout bit wrap, inout bit err, input int modv,
                            input bit en, input bit dir, input bit load, input int lidx);
    wrap = 0;
    if (load) begin
      if (lidx < modv) idx = lidx;
      else begin idx = 0; err = 1; end
    end else if (idx >= modv) begin
      idx = 0;
    end else if (en) begin
      if (!dir) begin wrap = (idx == modv - 1); idx = (idx + 1) % modv; end
      else      begin wrap = (idx == 0);        idx = (idx + modv - 1) % modv; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(mj_idx, mj_wrap, mj_err, J_MOD, jb.en, jb.dir, jb.load, int'(jb.load_idx));
      model_step(mg_idx, mg_wrap, mg_err, G_MOD, gb.en, gb.dir, gb.load, int'(gb.load_idx));
    end
    #1;
    $display("t=%0t j: idx=%0d state=%b wrap=%b err=%b | g: idx=%0d state=%b wrap=%b err=%b",
             $time, jb.index, jb.state, jb.wrap, jb.err, gb.index, gb.state, gb.wrap, gb.err);
  endtask

  task automatic drive_j(input bit e, input bit d, input bit l, input int li);
    @(negedge clk);
    jb.en = e; jb.dir = d; jb.load = l; jb.load_idx = J_IDXW'(li);
  endtask

  task automatic drive_g(input bit e, input bit d, input bit l, input int li);
    @(negedge clk);
    gb.en = e; gb.dir = d; gb.load = l; gb.load_idx = G_IDXW'(li);
  endtask

  task automatic idle_all();
    jb.en = 0; jb.dir = 0; jb.load = 0; jb.load_idx = '0;
    gb.en = 0; gb.dir = 0; gb.load = 0; gb.load_idx = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_all();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (jb.state !== jtab[0] || int'(jb.index) !== 0 || jb.wrap !== 1'b0 || jb.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_j: got state=%b idx=%0d wrap=%b err=%b, want state=%b idx=0 wrap=0 err=0",
               jb.state, jb.index, jb.wrap, jb.err, jtab[0]);
    end
    checks++;
    if (gb.state !== gtab[0] || int'(gb.index) !== 0 || gb.wrap !== 1'b0 || gb.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_g: got state=%b idx=%0d wrap=%b err=%b, want 0000/0/0/0",
               gb.state, gb.index, gb.wrap, gb.err);
    end
    drive_j(1, 0, 0, 0); drive_g(1, 0, 0, 0);
    tick(); tick(); tick();
    // Assert reset mid-cycle and look before any clock edge.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (jb.state !== 3'b000 || int'(jb.index) !== 0 || jb.wrap !== 1'b0 || jb.err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_j: got state=%b idx=%0d wrap=%b err=%b, want 000/0/0/0",
               jb.state, jb.index, jb.wrap, jb.err);
    end
    checks++;
    if (int'(gb.index) !== 0 || gb.state !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset_g: got state=%b idx=%0d, want 0000/0", gb.state, gb.index);
    end
    model_reset();
    @(negedge clk);
    idle_all();
    rst = 1'b0;
  endtask

  task automatic test_forward();
    logic [J_W-1:0] expect_seq [7];
    logic [J_W-1:0] prev;
    expect_seq = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b100, 3'b000, 3'b001};
    do_reset();
    drive_j(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      prev = jb.state;
      tick();
      checks++;
      if (jb.state !== expect_seq[i] || jb.state !== jtab[mj_idx] || int'(jb.index) !== mj_idx ||
          jb.wrap !== mj_wrap || jb.wrap !== (expect_seq[i] == 3'b000) || $countones(prev ^ jb.state) != 1) begin
        errors++;
        $display("FAIL forward_%0d: got state=%b idx=%0d wrap=%b, want state=%b idx=%0d wrap=%b",
                 i, jb.state, jb.index, jb.wrap, expect_seq[i], mj_idx, mj_wrap);
      end
    end
  endtask

  task automatic test_backward_wrap();
    int exp_idx [4];
    bit exp_wrap [4];
    bit dirs [4];
    exp_idx = '{5, 4, 5, 0};
    exp_wrap = '{1, 0, 0, 1};
    dirs = '{1, 1, 0, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_j(1, dirs[i], 0, 0);
      tick();
      checks++;
      if (int'(jb.index) !== exp_idx[i] || jb.wrap !== exp_wrap[i] || jb.state !== jtab[exp_idx[i]]) begin
        errors++;
        $display("FAIL backward_%0d: got idx=%0d wrap=%b state=%b, want idx=%0d wrap=%b state=%b",
                 i, jb.index, jb.wrap, jb.state, exp_idx[i], exp_wrap[i], jtab[exp_idx[i]]);
      end
    end
    // Reversal across the boundary gives wrap on adjacent cycles.
    drive_j(1, 1, 0, 0); tick();
    checks++;
    if (int'(jb.index) !== 5 || jb.wrap !== 1'b1) begin
      errors++;
      $display("FAIL reverse_back: got idx=%0d wrap=%b, want idx=5 wrap=1", jb.index, jb.wrap);
    end
    drive_j(1, 0, 0, 0); tick();
    checks++;
    if (int'(jb.index) !== 0 || jb.wrap !== 1'b1) begin
      errors++;
      $display("FAIL reverse_fwd: got idx=%0d wrap=%b, want idx=0 wrap=1", jb.index, jb.wrap);
    end
  endtask

  task automatic test_load_err();
    do_reset();
    drive_j(1, 0, 1, 3); tick();
    checks++;
    if (jb.state !== 3'b111 || int'(jb.index) !== 3 || jb.wrap !== 1'b0 || jb.err !== 1'b0) begin
      errors++;
      $display("FAIL load_3: got state=%b idx=%0d wrap=%b err=%b, want 111/3/0/0",
               jb.state, jb.index, jb.wrap, jb.err);
    end
    drive_j(1, 0, 1, 7); tick();
    checks++;
    if (int'(jb.index) !== 0 || jb.err !== 1'b1 || jb.wrap !== 1'b0 || jb.state !== 3'b000) begin
      errors++;
      $display("FAIL load_7: got idx=%0d err=%b wrap=%b state=%b, want 0/1/0/000",
               jb.index, jb.err, jb.wrap, jb.state);
    end
    drive_j(1, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (jb.err !== 1'b1 || int'(jb.index) !== mj_idx || jb.wrap !== mj_wrap) begin
        errors++;
        $display("FAIL err_sticky_%0d: got err=%b idx=%0d wrap=%b, want err=1 idx=%0d wrap=%b",
                 i, jb.err, jb.index, jb.wrap, mj_idx, mj_wrap);
      end
    end
    do_reset();
    #1;
    checks++;
    if (jb.err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%b, want 0", jb.err);
    end
  endtask

  task automatic test_gray();
    logic [G_W-1:0] prev;
    do_reset();
    drive_g(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      prev = gb.state;
      tick();
      checks++;
      if (gb.state !== gtab[mg_idx] || int'(gb.index) !== mg_idx || gb.wrap !== mg_wrap ||
          $countones(prev ^ gb.state) != 1 || gb.wrap !== (i == 15)) begin
        errors++;
        $display("FAIL gray_%0d: got state=%b idx=%0d wrap=%b, want state=%b idx=%0d wrap=%b",
                 i, gb.state, gb.index, gb.wrap, gtab[mg_idx], mg_idx, mg_wrap);
      end
    end
  endtask

  task automatic test_hold_backdoor();
    do_reset();
    drive_j(0, 0, 1, 2); tick();
    for (int i = 0; i < 5; i++) begin
      drive_j(0, i[0], 0, 0);
      tick();
      checks++;
      if (jb.state !== 3'b011 || int'(jb.index) !== 2 || jb.wrap !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: got state=%b idx=%0d wrap=%b, want 011/2/0", i, jb.state, jb.index, jb.wrap);
      end
    end
    @(negedge clk);
    force dut_j.index_reg = 3'd6;
    #1 release dut_j.index_reg;
    mj_idx = 6;
    tick();
    checks++;
    if (int'(jb.index) !== 0 || jb.state !== 3'b000 || jb.err !== 1'b0 || jb.wrap !== 1'b0) begin
      errors++;
      $display("FAIL seu_recover: got idx=%0d state=%b err=%b wrap=%b, want 0/000/0/0",
               jb.index, jb.state, jb.err, jb.wrap);
    end
  endtask

  task automatic test_random();
    logic [J_W-1:0] jprev;
    logic [G_W-1:0] gprev;
    bit jstep, gstep;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      jb.en = 1'($urandom); jb.dir = 1'($urandom); jb.load = ($urandom_range(0, 9) == 0);
      jb.load_idx = J_IDXW'($urandom_range(0, 7));
      gb.en = 1'($urandom); gb.dir = 1'($urandom); gb.load = ($urandom_range(0, 9) == 0);
      gb.load_idx = G_IDXW'($urandom_range(0, 15));
      jstep = jb.en && !jb.load; gstep = gb.en && !gb.load;
      jprev = jb.state; gprev = gb.state;
      tick();
      checks++;
      if (int'(jb.index) !== mj_idx || jb.state !== jtab[mj_idx] || jb.wrap !== mj_wrap || jb.err !== mj_err ||
          (jstep && $countones(jprev ^ jb.state) != 1)) begin
        errors++;
        $display("FAIL rand_j_%0d: got idx=%0d state=%b wrap=%b err=%b, want idx=%0d state=%b wrap=%b err=%b",
                 i, jb.index, jb.state, jb.wrap, jb.err, mj_idx, jtab[mj_idx], mj_wrap, mj_err);
      end
      checks++;
      if (int'(gb.index) !== mg_idx || gb.state !== gtab[mg_idx] || gb.wrap !== mg_wrap || gb.err !== mg_err ||
          (gstep && $countones(gprev ^ gb.state) != 1)) begin
        errors++;
        $display("FAIL rand_g_%0d: got idx=%0d state=%b wrap=%b err=%b, want idx=%0d state=%b wrap=%b err=%b",
                 i, gb.index, gb.state, gb.wrap, gb.err, mg_idx, gtab[mg_idx], mg_wrap, mg_err);
      end
    end
  endtask

  initial begin
    idle_all();
    build_tables();
    model_reset();
    test_reset();
    test_forward();
    test_backward_wrap();
    test_load_err();
    test_gray();
    test_hold_backdoor();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
Parametrised up/down sequence counter. Each step changes exactly one bit of the output code. It generalises the fixed 3-bit, 6-state direction-controlled stepper into two code families: a WIDTH-bit Johnson code (2*WIDTH states) or a reflected binary Gray code (2^WIDTH states). It adds an asynchronous reset, count enable, synchronous index load, a wrap pulse and a sticky error flag. It is used as a sequencing core in control/display logic; downstream logic decodes the registered code or the registered index.

Parameters:
WIDTH, 3, code width in bits; legal range 2..16.
MODE, 0, 0 = Johnson (MOD = 2*WIDTH); 1 = reflected Gray (MOD = 2^WIDTH).
RESET_IDX, 0, sequence index loaded on reset; must be < MOD.
(derived) MOD = number of states; IDXW = max(1, clog2(MOD)).

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
en  in  1  count enable; steps one position per clk when high
dir  in  1  0 = forward (index+1), 1 = backward (index-1)
load  in  1  synchronous load of load_idx; priority over en
load_idx  in  IDXW  index to load
state  out  WIDTH  registered code for current index
index  out  IDXW  registered current sequence index, 0..MOD-1
wrap  out  1  registered one-cycle pulse when the sequence wraps
err  out  1  sticky flag: out-of-range load attempted

Behaviour:
- Encoding, k = index:
  - Johnson: for k <= WIDTH, the low k bits are 1 and the rest 0. For WIDTH < k < 2*WIDTH, the low (k-WIDTH) bits are 0 and the rest 1. WIDTH=3 gives 000,001,011,111,110,100.
  - Gray: state = k ^ (k >> 1).
- Reset (async assert, released synchronously by the environment): index=RESET_IDX, state=encode(RESET_IDX), wrap=0, err=0. Takes effect immediately, including mid-count or mid-load.
- index and state are both registered and updated on the same edge. state always equals encode(index); no combinational path from inputs to outputs.
- Per-edge priority: load > en > hold.
  - load=1 with load_idx < MOD: index <= load_idx; wrap <= 0; err unchanged.
  - load=1 with load_idx >= MOD (only possible in Johnson mode): index <= 0; err <= 1; wrap <= 0.
  - load=0, en=1, dir=0: index <= (index==MOD-1) ? 0 : index+1. wrap <= 1 only on the MOD-1 -> 0 step.
  - load=0, en=1, dir=1: index <= (index==0) ? MOD-1 : index-1. wrap <= 1 only on the 0 -> MOD-1 step.
  - en=0, load=0: index and state hold; wrap <= 0.
- Latency: one clk from en/dir/load sampled to new state/index visible.
- wrap is high for exactly one cycle per wrap event. Back-to-back wraps are possible only when MOD=... (not for legal WIDTH); consecutive steps never produce wrap on adjacent cycles except by direction reversal at the boundary:
  - 0 -> MOD-1 (dir=1) then MOD-1 -> 0 (dir=0) pulses wrap on both cycles.
- dir may change every cycle; each step uses the dir sampled on that edge.
- Every forward or backward step changes exactly one bit of state, including the wrap step.
- err clears only on rst.
- Arithmetic is done in IDXW bits, with the explicit compare-and-wrap above, never native modulo. This matters because MOD is not a power of 2 in Johnson mode.
- Illegal register contents (e.g. after SEU) with index >= MOD: the next enabled step or hold forces index <= 0 and state <= encode(0). No err is set.

Test Plan:
- Reset, WIDTH=3, MODE=0, RESET_IDX=0, rst pulsed mid-count -> state=000, index=0, wrap=0, err=0 immediately (async), with no clk edge.
- en=1, dir=0 for 7 clks from index 0 -> state 001,011,111,110,100,000,001. wrap=1 only in the cycle showing 000. Each step changes exactly 1 bit.
- en=1, dir=1 from index 0 -> state 100 (index 5), wrap=1, then 110 (index 4), wrap=0. Then dir=0 for 2 clks -> index 5, then 0 with wrap=1.
- load=1, en=1, load_idx=3 -> next state 111, index 3, wrap=0. Then load_idx=7 (>=6) -> index 0, err=1. err stays 1 through 20 counting cycles until rst.
- MODE=1, WIDTH=4, dir=0, 16 clks from 0 -> Gray sequence 0000,0001,0011,0010,...,1000,0000. wrap=1 on 1000 -> 0000. Hamming distance is 1 on every step.
- en=0 with dir toggling for 5 clks at index 2 -> state 011 held, wrap=0. Force index=6 via backdoor (MODE=0) -> next edge index=0, state=000.
